// File: rtl/branch_history_tracker.sv
`default_nettype none
// ============================================================================
// Module      : branch_history_tracker
// Description : Fetch/resolve companion to a gshare-style 2-bit counter table.
//               Keeps a speculative and a committed global history register,
//               forms the table lookup index, queues in-flight predictions,
//               drives in-order table updates and repairs history / flushes
//               younger branches on a misprediction.
//
// Ports       : clk           - clock, all state updates on rising edge
//               rst_n         - synchronous active-low reset
//               fetch_valid   - conditional branch fetched this cycle
//               fetch_pc      - PC of the fetched branch
//               fetch_predict - table prediction for lookup_idx
//               fetch_ready   - tracker can accept a branch (count < DEPTH)
//               lookup_idx    - combinational table index (PC ^ spec GHR)
//               res_valid     - oldest in-flight branch resolved this cycle
//               res_taken     - actual outcome of that branch
//               upd_valid     - registered table-update strobe
//               upd_idx       - table index to update
//               upd_taken     - actual outcome for the table update
//               mispredict    - registered one-cycle flush pulse
//               ghr           - current speculative GHR
//               count         - in-flight entry count
//
// Revision    : 1.0 - initial release
// ============================================================================
module branch_history_tracker #(
    parameter int IDX_W  = 12,
    parameter int HIST_W = 12,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_valid,
    input  logic [31:0]                fetch_pc,
    input  logic                       fetch_predict,
    output logic                       fetch_ready,
    output logic [IDX_W-1:0]           lookup_idx,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       upd_valid,
    output logic [IDX_W-1:0]           upd_idx,
    output logic                       upd_taken,
    output logic                       mispredict,
    output logic [HIST_W-1:0]          ghr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [HIST_W-1:0]  r_spec_ghr;
    logic [HIST_W-1:0]  r_arch_ghr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic               r_upd_valid;
    logic [IDX_W-1:0]   r_upd_idx;
    logic               r_upd_taken;
    logic               r_mispredict;

    // In-flight prediction queue (index used for lookup + predicted direction)
    logic [IDX_W-1:0]   r_fifo_idx  [DEPTH];
    logic               r_fifo_pred [DEPTH];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]   w_ghr_ext;
    logic [HIST_W-1:0]  w_spec_shift;
    logic [HIST_W-1:0]  w_arch_shift;
    logic               w_accept;
    logic               w_resolve;
    logic               w_mispredict;
    logic [IDX_W-1:0]   w_head_idx;
    logic               w_head_pred;
    logic [c_CNT_W-1:0] w_count_next;
    logic               w_unused_pc;

    // History is narrower than (or equal to) the index; zero-extend it.
    assign w_ghr_ext  = IDX_W'(r_spec_ghr);
    assign lookup_idx = fetch_pc[IDX_W+1:2] ^ w_ghr_ext;

    // Only the word-aligned index bits of the PC take part in hashing.
    assign w_unused_pc = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0]};

    // History shift: a one-bit history simply holds the latest outcome.
    generate
        if (HIST_W == 1) begin : g_hist_one
            assign w_spec_shift = fetch_predict;
            assign w_arch_shift = res_taken;
        end else begin : g_hist_multi
            assign w_spec_shift = {r_spec_ghr[HIST_W-2:0], fetch_predict};
            assign w_arch_shift = {r_arch_ghr[HIST_W-2:0], res_taken};
        end
    endgenerate

    // Ready is purely a function of the registered count, so a resolve in
    // the same cycle never opens a slot for a fetch (no bypass path).
    assign fetch_ready = (r_count != c_CNT_W'(DEPTH));

    assign w_accept     = fetch_valid & fetch_ready;
    assign w_resolve    = res_valid & (r_count != '0);
    assign w_head_idx   = r_fifo_idx[r_rd_ptr];
    assign w_head_pred  = r_fifo_pred[r_rd_ptr];
    assign w_mispredict = w_resolve & (res_taken != w_head_pred);

    always_comb begin
        w_count_next = r_count;
        unique case ({w_accept, w_resolve})
            2'b10:   w_count_next = r_count + c_CNT_W'(1);
            2'b01:   w_count_next = r_count - c_CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // ------------------------------------------------------------------
    // Control and history registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_spec_ghr   <= '0;
            r_arch_ghr   <= '0;
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_upd_valid  <= 1'b0;
            r_upd_idx    <= '0;
            r_upd_taken  <= 1'b0;
            r_mispredict <= 1'b0;
        end else begin
            r_upd_valid  <= w_resolve;
            r_mispredict <= w_mispredict;

            if (w_resolve) begin
                r_upd_idx   <= w_head_idx;
                r_upd_taken <= res_taken;
                r_arch_ghr  <= w_arch_shift;
            end

            if (w_mispredict) begin
                // Flush wins over any concurrent fetch: everything younger
                // than the resolving branch is discarded and speculative
                // history is rebuilt from the committed history.
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_spec_ghr <= w_arch_shift;
            end else begin
                r_count <= w_count_next;
                if (w_accept) begin
                    r_wr_ptr   <= r_wr_ptr + c_PTR_W'(1);
                    r_spec_ghr <= w_spec_shift;
                end
                if (w_resolve) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Queue storage (contents are qualified by count, so no reset needed)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n && w_accept && !w_mispredict) begin
            r_fifo_idx[r_wr_ptr]  <= lookup_idx;
            r_fifo_pred[r_wr_ptr] <= fetch_predict;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign upd_valid  = r_upd_valid;
    assign upd_idx    = r_upd_idx;
    assign upd_taken  = r_upd_taken;
    assign mispredict = r_mispredict;
    assign ghr        = r_spec_ghr;
    assign count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_history_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_history_tracker
// Description : Self-checking bench for branch_history_tracker. A queue-based
//               reference model predicts every output; directed scenarios are
//               followed by a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_history_tracker;

    localparam int IDX_W  = 12;
    localparam int HIST_W = 12;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst_n;
    logic              fetch_valid;
    logic [31:0]       fetch_pc;
    logic              fetch_predict;
    logic              fetch_ready;
    logic [IDX_W-1:0]  lookup_idx;
    logic              res_valid;
    logic              res_taken;
    logic              upd_valid;
    logic [IDX_W-1:0]  upd_idx;
    logic              upd_taken;
    logic              mispredict;
    logic [HIST_W-1:0] ghr;
    logic [CNT_W-1:0]  count;

    branch_history_tracker #(
        .IDX_W  (IDX_W),
        .HIST_W (HIST_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .fetch_predict (fetch_predict),
        .fetch_ready   (fetch_ready),
        .lookup_idx    (lookup_idx),
        .res_valid     (res_valid),
        .res_taken     (res_taken),
        .upd_valid     (upd_valid),
        .upd_idx       (upd_idx),
        .upd_taken     (upd_taken),
        .mispredict    (mispredict),
        .ghr           (ghr),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             pred;
    } ent_t;

    ent_t              q[$];
    logic [HIST_W-1:0] m_spec;
    logic [HIST_W-1:0] m_arch;
    logic              m_upd_valid;
    logic [IDX_W-1:0]  m_upd_idx;
    logic              m_upd_taken;
    logic              m_mis;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic head_pred();
        return (q.size() != 0) ? q[0].pred : 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_spec      = '0;
        m_arch      = '0;
        m_upd_valid = 1'b0;
        m_upd_idx   = '0;
        m_upd_taken = 1'b0;
        m_mis       = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ":count"},      count,       q.size());
        chk({tag, ":ghr"},        ghr,         m_spec);
        chk({tag, ":upd_valid"},  upd_valid,   m_upd_valid);
        chk({tag, ":upd_idx"},    upd_idx,     m_upd_idx);
        chk({tag, ":upd_taken"},  upd_taken,   m_upd_taken);
        chk({tag, ":mispredict"}, mispredict,  m_mis);
        chk({tag, ":ready"},      fetch_ready, q.size() < DEPTH);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        fetch_valid   = 1'b1;
        fetch_pc      = $urandom;
        fetch_predict = 1'b1;
        res_valid     = 1'b0;
        res_taken     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_state("reset");
        rst_n       = 1'b1;
        fetch_valid = 1'b0;
    endtask

    // One clock cycle: drive inputs, check combinational outputs, advance
    // the model by the architectural rules, then check registered outputs.
    task automatic step(input string tag, input logic fv, input logic [31:0] pc,
                        input logic pr, input logic rv, input logic rt);
        logic [IDX_W-1:0] lidx;
        logic             acc;
        logic             res;
        logic             mis;
        ent_t             e;
        fetch_valid   = fv;
        fetch_pc      = pc;
        fetch_predict = pr;
        res_valid     = rv;
        res_taken     = rt;
        #1;
        lidx = pc[IDX_W+1:2] ^ IDX_W'(m_spec);
        if (fv) chk({tag, ":lookup_idx"}, lookup_idx, lidx);

        acc = fv && (q.size() < DEPTH);
        res = rv && (q.size() != 0);
        mis = 1'b0;
        m_upd_valid = res;
        if (res) begin
            e           = q.pop_front();
            m_upd_idx   = e.idx;
            m_upd_taken = rt;
            m_arch      = (m_arch << 1) | HIST_W'(rt);
            if (rt != e.pred) begin
                mis = 1'b1;
                q.delete();
                m_spec = m_arch;
            end
        end
        m_mis = mis;
        if (acc && !mis) begin
            e.idx  = lidx;
            e.pred = pr;
            q.push_back(e);
            m_spec = (m_spec << 1) | HIST_W'(pr);
        end

        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst_n         = 1'b0;
        fetch_valid   = 1'b0;
        fetch_pc      = '0;
        fetch_predict = 1'b0;
        res_valid     = 1'b0;
        res_taken     = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset with a fetch held active
        do_reset();
        chk("reset_ready_const", fetch_ready, 1'b1);
        chk("reset_count_const", count, 0);

        // Index formation: build ghr=0x005, drain, then fetch PC 0x40
        step("build", 1'b1, 32'h0000_1000, 1'b1, 1'b0, 1'b0);
        step("build", 1'b1, 32'h0000_2004, 1'b0, 1'b0, 1'b0);
        step("build", 1'b1, 32'h0000_3008, 1'b1, 1'b0, 1'b0);
        step("drain", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        step("drain", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step("drain", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("pre_idx_ghr", ghr, 12'h005);
        chk("pre_idx_count", count, 0);
        fetch_valid = 1'b1;
        fetch_pc    = 32'h0000_0040;
        #1;
        chk("lookup_0x015", lookup_idx, 12'h015);
        step("idx", 1'b1, 32'h0000_0040, 1'b1, 1'b0, 1'b0);
        chk("idx_ghr_0x00B", ghr, 12'h00B);
        chk("idx_count_1", count, 1);

        // Correct resolve of the single entry
        step("resolve_ok", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("ok_upd_idx", upd_idx, 12'h015);
        chk("ok_upd_taken", upd_taken, 1'b1);
        chk("ok_mispredict", mispredict, 1'b0);

        // Mispredict flush with a concurrent fetch
        do_reset();
        step("mp_fill", 1'b1, $urandom, 1'b1, 1'b0, 1'b0);
        step("mp_fill", 1'b1, $urandom, 1'b1, 1'b0, 1'b0);
        step("mp_fill", 1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        step("mp_flush", 1'b1, $urandom, 1'b1, 1'b1, 1'b0);
        chk("mp_pulse", mispredict, 1'b1);
        chk("mp_count", count, 0);
        chk("mp_ghr", ghr, 12'h000);
        chk("mp_upd_taken", upd_taken, 1'b0);
        step("mp_after", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Full and pointer wrap
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            step("full_fill", 1'b1, $urandom, 1'($urandom), 1'b0, 1'b0);
        chk("full_ready", fetch_ready, 1'b0);
        step("full_extra", 1'b1, $urandom, 1'b1, 1'b0, 1'b0);
        chk("full_count", count, DEPTH);
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                step("wrap_res", 1'b0, 32'h0, 1'b0, 1'b1, head_pred());
            else
                step("wrap_acc", 1'b1, $urandom, 1'($urandom), 1'b0, 1'b0);
        end
        while (q.size() != 0)
            step("wrap_drain", 1'b0, 32'h0, 1'b0, 1'b1, head_pred());

        // Empty resolve
        do_reset();
        step("empty_res", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("empty_upd_valid", upd_valid, 1'b0);
        chk("empty_ghr", ghr, 12'h000);

        // Randomized traffic, mostly correct predictions
        for (int i = 0; i < 600; i++) begin
            logic fv, pr, rv, rt;
            fv = ($urandom_range(0, 9) < 6);
            pr = 1'($urandom);
            rv = ($urandom_range(0, 9) < 5);
            rt = ($urandom_range(0, 99) < 85) ? head_pred() : ~head_pred();
            step("rand", fv, $urandom, pr, rv, rt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
